// File: rtl/irq_entry_ctrl_if.sv
// Signal bundle between the CPU control FSM and the interrupt entry controller.
// The CPU side (master) drives requests, masks and the boundary/eret pulses;
// the controller (slave) returns the entry-sequence controls and status.
interface irq_entry_ctrl_if #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);
  // Requests and CPU status
  logic [N_IRQ-1:0] irq;
  logic [N_IRQ-1:0] irq_en;
  logic             cpsr_i;
  logic             boundary;
  logic             eret;

  // Entry-sequence controls back to the CPU FSM
  logic             int_go;
  logic             save_lr;
  logic             save_spsr;
  logic             set_cpsr;
  logic             load_pc;
  logic [31:0]      vec_addr;

  // Status towards requesters
  logic [ID_W-1:0]  int_id;
  logic [N_IRQ-1:0] irq_ack;
  logic             in_service;
  logic [N_IRQ-1:0] pending;

  modport master (
    output irq, irq_en, cpsr_i, boundary, eret,
    input  int_go, save_lr, save_spsr, set_cpsr, load_pc, vec_addr,
           int_id, irq_ack, in_service, pending
  );

  modport slave (
    input  irq, irq_en, cpsr_i, boundary, eret,
    output int_go, save_lr, save_spsr, set_cpsr, load_pc, vec_addr,
           int_id, irq_ack, in_service, pending
  );
endinterface

// File: rtl/irq_entry_ctrl.sv
// Interrupt entry controller for the multi-cycle CPU.
// Captures rising edges on the request lines, masks them with the per-line
// enables and the CPSR I bit, grants the lowest-numbered eligible line at an
// instruction boundary, then walks the CPU through the four entry steps
// (save LR, save SPSR, set CPSR, load vector PC) and holds in-service status
// until exception return. No nesting: a new grant needs a return to IDLE.
module irq_entry_ctrl #(
  parameter int          N_IRQ    = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0020
) (
  input logic               clk,
  input logic               rst,
  irq_entry_ctrl_if.slave   bus
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_LR,
    S_SAVE_SPSR,
    S_SET_CPSR,
    S_LOAD_PC,
    S_SERVICE
  } state_t;

  state_t           state_q, state_d;

  // Edge capture
  logic [N_IRQ-1:0] irq_prev_q;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] rise;

  // Arbitration
  logic [N_IRQ-1:0] elig;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic             grant;
  logic [N_IRQ-1:0] ack_d;

  // Registered outputs
  logic             int_go_q;
  logic             save_lr_q;
  logic             save_spsr_q;
  logic             set_cpsr_q;
  logic             load_pc_q;
  logic             in_service_q;
  logic [N_IRQ-1:0] irq_ack_q;
  logic [ID_W-1:0]  int_id_q;
  logic [31:0]      vec_addr_q;

  assign rise = bus.irq & ~irq_prev_q;
  assign elig = pending_q & bus.irq_en & {N_IRQ{~bus.cpsr_i}};

  // Fixed-priority pick: scan from the top so the lowest set index wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    win_id    = '0;
    win_found = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_id    = ID_W'(i);
        win_found = 1'b1;
      end
    end
  end

  // A grant only happens from IDLE at an instruction boundary.
  always_comb begin
    grant = (state_q == S_IDLE) && bus.boundary && win_found;
    ack_d = grant ? (N_IRQ'(1) << win_id) : '0;
  end

  // Next-state logic for the entry sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (grant) state_d = S_SAVE_LR;
      S_SAVE_LR:   state_d = S_SAVE_SPSR;
      S_SAVE_SPSR: state_d = S_SET_CPSR;
      S_SET_CPSR:  state_d = S_LOAD_PC;
      S_LOAD_PC:   state_d = S_SERVICE;
      S_SERVICE:   if (bus.eret) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values
    // of its inputs, independent of the order the always blocks are evaluated.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Edge detector and pending set/clear; a new edge wins over the acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= bus.irq;
      pending_q  <= (pending_q & ~ack_d) | rise;
    end
  end

  // Outputs decoded from the next state so each is high while its state is current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_go_q     <= 1'b0;
      save_lr_q    <= 1'b0;
      save_spsr_q  <= 1'b0;
      set_cpsr_q   <= 1'b0;
      load_pc_q    <= 1'b0;
      in_service_q <= 1'b0;
      irq_ack_q    <= '0;
    end else begin
      int_go_q     <= state_d inside {S_SAVE_LR, S_SAVE_SPSR, S_SET_CPSR, S_LOAD_PC};
      save_lr_q    <= (state_d == S_SAVE_LR);
      save_spsr_q  <= (state_d == S_SAVE_SPSR);
      set_cpsr_q   <= (state_d == S_SET_CPSR);
      load_pc_q    <= (state_d == S_LOAD_PC);
      in_service_q <= (state_d != S_IDLE);
      irq_ack_q    <= ack_d;
    end
  end

  // Granted id and its vector; held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_id_q   <= '0;
      vec_addr_q <= '0;
    end else if (grant) begin
      int_id_q   <= win_id;
      vec_addr_q <= VEC_BASE + (32'(win_id) << 2);
    end
  end

  assign bus.int_go     = int_go_q;
  assign bus.save_lr    = save_lr_q;
  assign bus.save_spsr  = save_spsr_q;
  assign bus.set_cpsr   = set_cpsr_q;
  assign bus.load_pc    = load_pc_q;
  assign bus.in_service = in_service_q;
  assign bus.irq_ack    = irq_ack_q;
  assign bus.int_id     = int_id_q;
  assign bus.vec_addr   = vec_addr_q;
  assign bus.pending    = pending_q;

  // The four entry steps are mutually exclusive.
  a_steps_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({save_lr_q, save_spsr_q, set_cpsr_q, load_pc_q}));

  // At most one requester is acknowledged at a time.
  a_ack_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(irq_ack_q));

  // The entry sequence is always part of an in-service period.
  a_go_in_service: assert property (@(posedge clk) disable iff (rst)
    int_go_q |-> in_service_q);

endmodule

// File: tb/tb_irq_entry_ctrl.sv
// Bench for irq_entry_ctrl: directed scenarios followed by random traffic.
// A behavioural model (pending set, busy flag, cycles since grant) predicts
// every output and is compared against the DUT after every clock edge.
module tb_irq_entry_ctrl;

  localparam int          N_IRQ    = 4;
  localparam logic [31:0] VEC_BASE = 32'h0000_0020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_entry_ctrl_if #(.N_IRQ(N_IRQ)) bus ();

  irq_entry_ctrl #(.N_IRQ(N_IRQ), .VEC_BASE(VEC_BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: since = cycles elapsed since the grant, saturating at 5 (service).
  typedef struct packed {
    logic [3:0]  pend;
    logic [3:0]  prev;
    logic        busy;
    logic [2:0]  since;
    logic [3:0]  ack;
    logic [1:0]  id;
    logic [31:0] vec;
  } model_t;

  model_t m = '0;

  function automatic model_t model_next(model_t cur, logic [3:0] irq, logic [3:0] en,
                                        logic ci, logic bnd, logic ret);
    model_t     n;
    logic [3:0] elig;
    int         w;
    n    = cur;
    elig = ci ? 4'b0000 : (cur.pend & en);
    w    = -1;
    for (int i = 0; i < 4; i++) if (w < 0 && elig[i]) w = i;
    n.ack = 4'b0000;
    if (!cur.busy && bnd && w >= 0) begin
      n.ack   = 4'(1 << w);
      n.id    = 2'(w);
      n.vec   = VEC_BASE + 32'(4 * w);
      n.busy  = 1'b1;
      n.since = 3'd1;
    end else if (cur.busy) begin
      if (cur.since < 3'd5) n.since = cur.since + 3'd1;
      else if (ret) begin
        n.busy  = 1'b0;
        n.since = 3'd0;
      end
    end
    n.pend = (cur.pend & ~n.ack) | (irq & ~cur.prev);
    n.prev = irq;
    return n;
  endfunction

  // Model advances on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, bus.irq, bus.irq_en, bus.cpsr_i, bus.boundary, bus.eret);
  end

  // Compare every output just after each active edge.
  always @(posedge clk) begin
    #1;
    check("int_go",     bus.int_go,     m.busy && m.since >= 3'd1 && m.since <= 3'd4);
    check("save_lr",    bus.save_lr,    m.since == 3'd1);
    check("save_spsr",  bus.save_spsr,  m.since == 3'd2);
    check("set_cpsr",   bus.set_cpsr,   m.since == 3'd3);
    check("load_pc",    bus.load_pc,    m.since == 3'd4);
    check("in_service", bus.in_service, m.busy);
    check("irq_ack",    bus.irq_ack,    m.ack);
    check("pending",    bus.pending,    m.pend);
    check("int_id",     bus.int_id,     m.id);
    check("vec_addr",   bus.vec_addr,   m.vec);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_boundary();
    bus.boundary = 1'b1;
    @(negedge clk);
    bus.boundary = 1'b0;
  endtask

  task automatic pulse_eret();
    bus.eret = 1'b1;
    @(negedge clk);
    bus.eret = 1'b0;
  endtask

  // Wait (bounded) until the entry steps are done and service has begun.
  task automatic wait_service();
    int k = 0;
    while (!(bus.in_service && !bus.int_go) && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("wait_service_done", k < 10, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_go"},   bus.int_go,     0);
    check({tag, "_ctl"},  {bus.save_lr, bus.save_spsr, bus.set_cpsr, bus.load_pc}, 0);
    check({tag, "_insv"}, bus.in_service, 0);
    check({tag, "_ack"},  bus.irq_ack,    0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    bus.irq      = '0;
    bus.irq_en   = 4'hF;
    bus.cpsr_i   = 1'b0;
    bus.boundary = 1'b0;
    bus.eret     = 1'b0;
    cyc(3);
    check_all_zero("reset");
    check("reset_pend", bus.pending, 0);
    check("reset_vec",  bus.vec_addr, 0);
    rst = 1'b0;
    cyc(1);

    // Single request on line 2: full entry sequence.
    bus.irq = 4'b0100;
    cyc(1);
    check("s1_pend_set", bus.pending, 4'b0100);
    pulse_boundary();
    check("s1_ack",     bus.irq_ack,  4'b0100);
    check("s1_save_lr", bus.save_lr,  1);
    check("s1_go",      bus.int_go,   1);
    check("s1_vec",     bus.vec_addr, 32'h28);
    check("s1_id",      bus.int_id,   2);
    check("s1_pend_clr", bus.pending, 0);
    check("s1_model_vec", m.vec, 32'h28);
    cyc(1);
    check("s1_save_spsr", bus.save_spsr, 1);
    check("s1_ack_gone",  bus.irq_ack,   0);
    cyc(1);
    check("s1_set_cpsr", bus.set_cpsr, 1);
    cyc(1);
    check("s1_load_pc", bus.load_pc, 1);
    check("s1_go4",     bus.int_go,  1);
    cyc(1);
    check("s1_service_go",   bus.int_go,     0);
    check("s1_service_insv", bus.in_service, 1);
    bus.irq = '0;
    pulse_eret();
    check("s1_ret_insv", bus.in_service, 0);

    // Lines 1 and 3 together: 1 first, 3 after return.
    bus.irq = 4'b1010;
    cyc(1);
    pulse_boundary();
    check("s2_id1",  bus.int_id,   1);
    check("s2_vec1", bus.vec_addr, 32'h24);
    check("s2_pend", bus.pending,  4'b1000);
    bus.irq = '0;
    wait_service();
    pulse_eret();
    pulse_boundary();
    check("s2_id3",  bus.int_id,   3);
    check("s2_vec3", bus.vec_addr, 32'h2C);
    check("s2_ack3", bus.irq_ack,  4'b1000);
    check("s2_model_vec3", m.vec, 32'h2C);
    wait_service();
    pulse_eret();

    // Masking by the I bit and by the enable mask.
    bus.cpsr_i = 1'b1;
    bus.irq    = 4'b0001;
    cyc(1);
    pulse_boundary();
    check("s3_cpsr_go",   bus.int_go,     0);
    check("s3_cpsr_insv", bus.in_service, 0);
    check("s3_cpsr_pend", bus.pending,    4'b0001);
    bus.cpsr_i = 1'b0;
    bus.irq_en = 4'b1110;
    pulse_boundary();
    check("s3_en_go", bus.int_go, 0);
    bus.irq_en = 4'hF;
    pulse_boundary();
    check("s3_grant_lr", bus.save_lr, 1);
    check("s3_grant_id", bus.int_id,  0);
    bus.irq = '0;
    wait_service();

    // New edge during service stays pending until after return.
    bus.irq = 4'b0001;
    cyc(1);
    check("s4_pend", bus.pending,    4'b0001);
    check("s4_insv", bus.in_service, 1);
    check("s4_go",   bus.int_go,     0);
    bus.irq = '0;
    pulse_eret();
    check("s4_ret", bus.in_service, 0);
    pulse_boundary();
    check("s4_id", bus.int_id,  0);
    check("s4_lr", bus.save_lr, 1);
    wait_service();
    pulse_eret();

    // Stray eret and empty boundary in IDLE do nothing.
    check("s6_pend_empty", bus.pending, 0);
    pulse_eret();
    check_all_zero("s6_eret");
    pulse_boundary();
    check_all_zero("s6_bnd");

    // Asynchronous reset in the middle of the entry sequence.
    bus.irq = 4'b0100;
    cyc(1);
    pulse_boundary();
    bus.irq = 4'b0110;
    cyc(2);
    check("s5_set_cpsr", bus.set_cpsr, 1);
    check("s5_pend_pre", bus.pending,  4'b0010);
    #2 rst = 1'b1;
    #1;
    check_all_zero("s5_rst");
    check("s5_rst_pend", bus.pending,  0);
    check("s5_rst_vec",  bus.vec_addr, 0);
    check("s5_rst_id",   bus.int_id,   0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("s5_first_clk_pend2", bus.pending[2], 1);
    check("s5_first_clk_pend",  bus.pending,    4'b0110);
    bus.irq = '0;
    pulse_boundary();
    wait_service();
    pulse_eret();
    pulse_boundary();
    wait_service();
    pulse_eret();

    // Random traffic checked by the per-cycle compare process.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] tog;
      tog = '0;
      for (int b = 0; b < 4; b++) tog[b] = ($urandom_range(0, 7) == 0);
      bus.irq      = bus.irq ^ tog;
      bus.irq_en   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      bus.cpsr_i   = ($urandom_range(0, 9) == 0);
      bus.boundary = ($urandom_range(0, 9) < 3);
      bus.eret     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    bus.boundary = 1'b0;
    bus.eret     = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
